// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        HEADER,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    function automatic int bytes_per_word(input int n);
        return n / BYTE_W;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes LSB-first into an N-bit word; word_valid pulses the cycle after the last byte.
// No backpressure of its own: the caller only presents bytes it has already accepted.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             last_byte,
    output logic             word_valid,
    output logic [N-1:0]     word_data
);

    localparam int BYTES = bytes_per_word(N);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0] idx;
    logic [N-1:0]     shreg;
    logic [N-1:0]     next_word;

    // New byte enters at the top so the first byte ends up in bits [7:0].
    assign next_word = (shreg >> BYTE_W) | (N'(byte_data) << (N - BYTE_W));
    assign last_byte = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx        <= '0;
            shreg      <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx   <= '0;
                shreg <= '0;
            end else if (byte_valid) begin
                shreg <= next_word;
                if (last_byte) begin
                    idx        <= '0;
                    word_valid <= 1'b1;
                    word_data  <= next_word;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header/payload/XOR-checksum byte stream into instruction memory, one write per word a cycle after its last byte.
// in_ready is high in HEADER/LOAD/CHECK and low once DONE or ERROR; stalls indefinitely on in_valid gaps.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = ADDR_W + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [7:0]       checksum;
    logic             accept;
    logic             load_take;
    logic             last_byte;
    logic             word_last;
    logic             last_word;
    logic             hdr_ok;

    assign in_ready  = (state == HEADER) || (state == LOAD) || (state == CHECK);
    assign accept    = in_valid && in_ready;
    assign load_take = accept && (state == LOAD);
    assign word_last = load_take && last_byte;
    assign last_word = ((words_loaded + CNT_W'(1)) == count);
    assign hdr_ok    = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(DEPTH));

    word_assembler #(.N(N)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == HEADER),
        .byte_valid (load_take),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_valid (wr_en),
        .word_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= HEADER;
            count        <= '0;
            checksum     <= '0;
            words_loaded <= '0;
            wr_addr      <= '0;
        end else begin
            state <= state_next;
            if (accept && (state == HEADER)) begin
                count <= in_data[CNT_W-1:0];
            end
            if (load_take) begin
                checksum <= checksum ^ in_data;
            end
            // Address and count advance on the edge the write strobe rises.
            if (word_last) begin
                wr_addr      <= words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            HEADER: if (accept) state_next = hdr_ok ? LOAD : ERROR;
            LOAD:   if (word_last && last_word) state_next = CHECK;
            CHECK:  if (accept) state_next = (in_data == checksum) ? DONE : ERROR;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERROR:  error = 1'b1;
            default: state_next = HEADER;
        endcase
    end

endmodule
